// File: rtl/icache_sa_pkg.sv
// Shared constants, FSM state type and width helpers for the set-associative I-cache.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package icache_sa_pkg;

  // Default geometry; module parameters fall back to these.
  localparam int ICACHE_WAYS        = 2;
  localparam int ICACHE_SETS        = 16;
  localparam int ICACHE_BLOCK_BYTES = 16;
  localparam int ICACHE_ADDR_BITS   = 17;

  // Miss FSM states.
  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

  // Tree PLRU needs WAYS-1 bits; a direct-mapped cache keeps one unused bit
  // so the storage declarations stay legal.
  function automatic int plru_bits(input int ways);
    return (ways > 1) ? ways - 1 : 1;
  endfunction

  function automatic int way_bits(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/icache_sa_plru.sv
// Tree pseudo-LRU mapping for one set: PLRU bits -> victim way, and
// (PLRU bits, accessed way) -> next PLRU bits. Purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the next bits are written.
// Ports: cur_bits (set's PLRU bits), access_way (way being touched),
//        victim (way to replace), bits_next (bits after touching access_way).
module icache_sa_plru
  import icache_sa_pkg::*;
#(
  parameter  int WAYS = ICACHE_WAYS,
  localparam int PW   = plru_bits(WAYS),
  localparam int WW   = way_bits(WAYS)
) (
  input  logic [PW-1:0] cur_bits,
  input  logic [WW-1:0] access_way,
  output logic [WW-1:0] victim,
  output logic [PW-1:0] bits_next
);

  // Each bit points toward the less recently used half of its subtree.
  if (WAYS == 4) begin : g_four
    // bit0 = root (0: pair 0/1, 1: pair 2/3), bit1 = pair 0/1, bit2 = pair 2/3.
    always_comb begin
      victim    = cur_bits[0] ? (cur_bits[2] ? 2'd3 : 2'd2)
                              : (cur_bits[1] ? 2'd1 : 2'd0);
      bits_next = cur_bits;
      bits_next[0] = ~access_way[1];
      if (access_way[1]) bits_next[2] = ~access_way[0];
      else               bits_next[1] = ~access_way[0];
    end
  end else if (WAYS == 2) begin : g_two
    assign victim    = cur_bits;
    assign bits_next = ~access_way;
  end else begin : g_one
    assign victim    = '0;
    assign bits_next = '0;
  end

endmodule

// File: rtl/icache_sa.sv
// Set-associative instruction cache with tree-PLRU refill and its own miss FSM.
// Latency: hits return in the request cycle; a miss costs memory latency + 1 cycle.
// Backpressure: rdy_in low freezes all state; fetch is held until inst_valid; one refill outstanding.
// Ports: fetch_valid/fetch_addr -> inst_valid/inst_out (fetch side), busy (FSM not idle),
//        flush (invalidate all), mem_req/mem_addr -> mem_done/mem_block (refill handshake).
module icache_sa
  import icache_sa_pkg::*;
#(
  parameter int WAYS        = ICACHE_WAYS,
  parameter int SETS        = ICACHE_SETS,
  parameter int BLOCK_BYTES = ICACHE_BLOCK_BYTES,
  parameter int ADDR_BITS   = ICACHE_ADDR_BITS
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     fetch_valid,
  input  logic [31:0]              fetch_addr,
  output logic                     inst_valid,
  output logic [31:0]              inst_out,
  output logic                     busy,
  input  logic                     flush,
  output logic                     mem_req,
  output logic [31:0]              mem_addr,
  input  logic                     mem_done,
  input  logic [BLOCK_BYTES*8-1:0] mem_block
);

  localparam int OFF_W  = $clog2(BLOCK_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_BITS - IDX_W - OFF_W;
  localparam int LINE_W = BLOCK_BYTES * 8;
  localparam int PW     = plru_bits(WAYS);
  localparam int WW     = way_bits(WAYS);

  logic              valid  [WAYS][SETS];
  logic [TAG_W-1:0]  tag_q  [WAYS][SETS];
  logic [LINE_W-1:0] data_q [WAYS][SETS];
  logic [PW-1:0]     plru_q [SETS];

  state_t state;
  logic   poison;

  // Fetch-side and refill-side address fields.
  logic [OFF_W-1:0] f_off;
  logic [IDX_W-1:0] f_idx, r_idx, p_idx;
  logic [TAG_W-1:0] f_tag, r_tag;

  assign f_off = fetch_addr[OFF_W-1:0];
  assign f_idx = fetch_addr[OFF_W +: IDX_W];
  assign f_tag = fetch_addr[ADDR_BITS-1 -: TAG_W];
  assign r_idx = mem_addr[OFF_W +: IDX_W];
  assign r_tag = mem_addr[ADDR_BITS-1 -: TAG_W];

  // Lookup.
  logic              hit;
  logic [WW-1:0]     hit_way;
  logic [LINE_W-1:0] hit_line;

  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid[w][f_idx] && tag_q[w][f_idx] == f_tag) begin
        hit      = 1'b1;
        hit_way  = WW'(w);
        hit_line = data_q[w][f_idx];
      end
    end
  end

  logic [OFF_W+2:0] bit_off;
  assign bit_off    = {f_off, 3'b000};
  assign inst_out   = hit ? hit_line[bit_off +: 32] : 32'h0;
  assign inst_valid = fetch_valid && hit && rdy_in && (state == ST_IDLE) && !flush;
  assign busy       = (state != ST_IDLE);

  // Victim: lowest invalid way of the refill set, else the PLRU choice.
  logic          inv_found;
  logic [WW-1:0] inv_way, plru_victim, fill_way, acc_way;
  logic [PW-1:0] plru_next;

  always_comb begin
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (!valid[w][r_idx]) begin
        inv_found = 1'b1;
        inv_way   = WW'(w);
      end
    end
  end

  // Hits only happen in IDLE and installs only in REFILL, so one PLRU
  // instance serves both: its set and accessed way follow the FSM state.
  assign p_idx    = (state == ST_REFILL) ? r_idx : f_idx;
  assign fill_way = inv_found ? inv_way : plru_victim;
  assign acc_way  = (state == ST_REFILL) ? fill_way : hit_way;

  icache_sa_plru #(.WAYS(WAYS)) u_plru (
    .cur_bits   (plru_q[p_idx]),
    .access_way (acc_way),
    .victim     (plru_victim),
    .bits_next  (plru_next)
  );

  // A flush sampled with mem_done, or any time earlier in the refill, drops the line.
  logic install;
  assign install = !rst_in && rdy_in && (state == ST_REFILL) && mem_done && !poison && !flush;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state    <= ST_IDLE;
      mem_req  <= 1'b0;
      mem_addr <= '0;
      poison   <= 1'b0;
      for (int w = 0; w < WAYS; w++)
        for (int s = 0; s < SETS; s++) valid[w][s] <= 1'b0;
      for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
    end else if (rdy_in) begin
      case (state)
        ST_IDLE: begin
          if (fetch_valid && !hit && !flush) begin
            state    <= ST_REFILL;
            mem_req  <= 1'b1;
            mem_addr <= {fetch_addr[31:OFF_W], {OFF_W{1'b0}}};
            poison   <= 1'b0;
          end
        end
        ST_REFILL: begin
          if (mem_done) begin
            state   <= ST_IDLE;
            mem_req <= 1'b0;
            poison  <= 1'b0;
          end else if (flush) begin
            poison <= 1'b1;
          end
        end
      endcase
      if (install) valid[fill_way][r_idx] <= 1'b1;
      if (install || inst_valid) plru_q[p_idx] <= plru_next;
      // Flush wins over an install or PLRU touch on the same edge.
      if (flush) begin
        for (int w = 0; w < WAYS; w++)
          for (int s = 0; s < SETS; s++) valid[w][s] <= 1'b0;
        for (int s = 0; s < SETS; s++) plru_q[s] <= '0;
      end
    end
  end

  // Tag and data arrays carry no reset; valid bits qualify them.
  always_ff @(posedge clk_in) begin
    if (install) begin
      tag_q[fill_way][r_idx]  <= r_tag;
      data_q[fill_way][r_idx] <= mem_block;
    end
  end

endmodule

// File: tb/tb_icache_sa.sv
// Self-checking bench for icache_sa at default geometry (2 ways, 16 sets, 16-byte lines).
// Directed scenarios with literal expectations, then randomized traffic against a
// true-LRU line-level reference model compared every cycle.
module tb_icache_sa;

  logic         clk_in;
  logic         rst_in, rdy_in, fetch_valid, flush, mem_done;
  logic [31:0]  fetch_addr;
  logic [127:0] mem_block;
  logic         inst_valid, busy, mem_req;
  logic [31:0]  inst_out, mem_addr;

  icache_sa dut (
    .clk_in      (clk_in),
    .rst_in      (rst_in),
    .rdy_in      (rdy_in),
    .fetch_valid (fetch_valid),
    .fetch_addr  (fetch_addr),
    .inst_valid  (inst_valid),
    .inst_out    (inst_out),
    .busy        (busy),
    .flush       (flush),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_done    (mem_done),
    .mem_block   (mem_block)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Memory image: hashed words, with block 0 pinned to known instructions.
  function automatic logic [127:0] blk(input logic [31:0] a);
    logic [127:0] b;
    for (int i = 0; i < 4; i++) b[i*32 +: 32] = ((a + i * 4) * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    if (a[16:4] == 13'd0) begin
      b[31:0]   = 32'h0000_0013;
      b[127:96] = 32'hFE01_0113;
    end
    return b;
  endfunction

  // ---------------- reference model: lines per set with use timestamps ----------------
  bit           m_valid [2][16];
  logic [8:0]   m_tag   [2][16];
  logic [127:0] m_data  [2][16];
  int           m_last  [2][16];
  bit           m_pend, m_poison;
  logic [31:0]  m_addr;
  int           m_served = 0;
  int           now = 0;
  int           mw, midx, mv, cw;
  logic [31:0]  e_out;
  bit           e_iv;

  function automatic int lookup(input logic [31:0] a);
    int idx;
    idx = int'(a[7:4]);
    for (int w = 0; w < 2; w++)
      if (m_valid[w][idx] && m_tag[w][idx] == a[16:8]) return w;
    return -1;
  endfunction

  always @(posedge clk_in) begin
    now++;
    if (rst_in) begin
      for (int w = 0; w < 2; w++) for (int s = 0; s < 16; s++) m_valid[w][s] = 1'b0;
      m_pend = 1'b0; m_poison = 1'b0; m_addr = 32'h0;
    end else if (rdy_in) begin
      mw   = lookup(fetch_addr);
      midx = int'(fetch_addr[7:4]);
      if (!m_pend) begin
        if (fetch_valid && !flush) begin
          if (mw >= 0) begin
            m_last[mw][midx] = now;
            m_served++;
          end else begin
            m_pend   = 1'b1;
            m_addr   = {fetch_addr[31:4], 4'h0};
            m_poison = 1'b0;
          end
        end
      end else if (mem_done) begin
        if (!m_poison && !flush) begin
          midx = int'(m_addr[7:4]);
          if (!m_valid[0][midx])      mv = 0;
          else if (!m_valid[1][midx]) mv = 1;
          else mv = (m_last[0][midx] < m_last[1][midx]) ? 0 : 1;
          m_valid[mv][midx] = 1'b1;
          m_tag[mv][midx]   = m_addr[16:8];
          m_data[mv][midx]  = mem_block;
          m_last[mv][midx]  = now;
        end
        m_pend = 1'b0; m_poison = 1'b0;
      end else if (flush) begin
        m_poison = 1'b1;
      end
      if (flush) for (int w = 0; w < 2; w++) for (int s = 0; s < 16; s++) m_valid[w][s] = 1'b0;
    end
  end

  always @(negedge clk_in) begin
    if (chk_en && !rst_in) begin
      cw    = lookup(fetch_addr);
      e_out = 32'h0;
      if (cw >= 0) e_out = m_data[cw][int'(fetch_addr[7:4])][int'(fetch_addr[3:2]) * 32 +: 32];
      e_iv  = fetch_valid && (cw >= 0) && rdy_in && !m_pend && !flush;
      chk("cmp_inst_valid", {31'h0, inst_valid}, {31'h0, e_iv});
      chk("cmp_inst_out",   inst_out, e_out);
      chk("cmp_busy",       {31'h0, busy},    {31'h0, m_pend});
      chk("cmp_mem_req",    {31'h0, mem_req}, {31'h0, m_pend});
      chk("cmp_mem_addr",   mem_addr, m_addr);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  // Pulse mem_done with the line for a; returns at the start of the cycle after the edge.
  task automatic refill_done(input logic [31:0] a);
    mem_done  = 1'b1;
    mem_block = blk(a);
    tick();
    mem_done  = 1'b0;
  endtask

  initial begin
    int          lat;
    bit          prev_pend;
    int          seen;
    logic [31:0] a;

    rst_in = 1'b1; rdy_in = 1'b1; fetch_valid = 1'b0; fetch_addr = 32'h0;
    flush = 1'b0; mem_done = 1'b0; mem_block = '0;
    repeat (2) tick();
    rst_in = 1'b0;
    chk_en = 1'b1;
    #2;
    chk("rst_mem_req",    {31'h0, mem_req},    32'd0);
    chk("rst_busy",       {31'h0, busy},       32'd0);
    chk("rst_mem_addr",   mem_addr,            32'h0);
    chk("rst_inst_valid", {31'h0, inst_valid}, 32'd0);

    // 1: cold miss at 0x00000
    fetch_valid = 1'b1; fetch_addr = 32'h0;
    #2 chk("t1_cold_no_valid", {31'h0, inst_valid}, 32'd0);
    tick();
    #2 chk("t1_mem_req", {31'h0, mem_req}, 32'd1);
    chk("t1_mem_addr", mem_addr, 32'h0);
    tick();
    refill_done(32'h0);
    #2 chk("t1_valid_after_done", {31'h0, inst_valid}, 32'd1);
    chk("t1_inst", inst_out, 32'h0000_0013);

    // 2: same-line hit on word 3
    tick(); fetch_addr = 32'h0000_000C;
    #2 chk("t2_hit_valid", {31'h0, inst_valid}, 32'd1);
    chk("t2_inst", inst_out, 32'hFE01_0113);
    chk("t2_no_req", {31'h0, mem_req}, 32'd0);

    // 3: PLRU eviction in set 0
    tick(); fetch_addr = 32'h100;
    tick(); tick(); refill_done(32'h100);
    fetch_addr = 32'h0;                       // touch 0x00000
    tick(); fetch_addr = 32'h200;
    tick(); tick(); refill_done(32'h200);
    tick(); fetch_addr = 32'h0;
    #2 chk("t3_keep_0", {31'h0, inst_valid}, 32'd1);
    chk("t3_keep_0_inst", inst_out, 32'h0000_0013);
    tick(); fetch_addr = 32'h100;
    #2 chk("t3_evicted_100", {31'h0, inst_valid}, 32'd0);
    tick();
    #2 chk("t3_req_100", {31'h0, mem_req}, 32'd1);
    chk("t3_addr_100", mem_addr, 32'h100);
    tick(); refill_done(32'h100);

    // 4: flush during refill poisons the line
    fetch_addr = 32'h300;
    #2 chk("t4_miss_300", {31'h0, inst_valid}, 32'd0);
    tick();
    #2 chk("t4_req_300", mem_addr, 32'h300);
    flush = 1'b1; tick(); flush = 1'b0;
    tick(); refill_done(32'h300);
    #2 chk("t4_poisoned_miss", {31'h0, inst_valid}, 32'd0);
    tick();
    #2 chk("t4_rereq", {31'h0, mem_req}, 32'd1);
    chk("t4_rereq_addr", mem_addr, 32'h300);
    tick(); refill_done(32'h300);
    fetch_addr = 32'h0;
    #2 chk("t4_flushed_0_miss", {31'h0, inst_valid}, 32'd0);
    tick();
    #2 chk("t4_req_0", {31'h0, mem_req}, 32'd1);
    chk("t4_req_0_addr", mem_addr, 32'h0);
    tick(); refill_done(32'h0);

    // 5: rdy_in low blocks a hit and its PLRU update, then freezes a refill
    tick(); fetch_addr = 32'h300; rdy_in = 1'b0;
    #2 chk("t5_rdy_low_no_valid", {31'h0, inst_valid}, 32'd0);
    tick(); rdy_in = 1'b1; fetch_addr = 32'h100;
    tick();
    #2 chk("t5_req_100", mem_addr, 32'h100);
    tick(); refill_done(32'h100);
    fetch_addr = 32'h0;
    #2 chk("t5_plru_kept", {31'h0, inst_valid}, 32'd1);
    tick(); fetch_addr = 32'h300;
    tick();
    #2 chk("t5_req_300", {31'h0, mem_req}, 32'd1);
    rdy_in = 1'b0;
    tick(); mem_done = 1'b1; mem_block = blk(32'h300);
    tick(); mem_done = 1'b0;
    #2 chk("t5_frozen_req", {31'h0, mem_req}, 32'd1);
    chk("t5_frozen_addr", mem_addr, 32'h300);
    chk("t5_frozen_busy", {31'h0, busy}, 32'd1);
    tick(); rdy_in = 1'b1;
    refill_done(32'h300);

    // 6: reset mid-refill
    tick(); fetch_addr = 32'h400;
    tick();
    #2 chk("t6_req_400", {31'h0, mem_req}, 32'd1);
    rst_in = 1'b1;
    tick(); rst_in = 1'b0; fetch_addr = 32'h0;
    #2 chk("t6_req_dropped", {31'h0, mem_req}, 32'd0);
    chk("t6_not_busy", {31'h0, busy}, 32'd0);
    chk("t6_0_misses", {31'h0, inst_valid}, 32'd0);
    tick();
    #2 chk("t6_req_0", mem_addr, 32'h0);
    tick(); refill_done(32'h0);
    fetch_valid = 1'b0;

    // Randomized traffic; a fetch is held until the model reports it served.
    lat = 0; prev_pend = 1'b0; seen = m_served;
    repeat (4000) begin
      tick();
      rdy_in = ($urandom_range(0, 9) != 0);
      flush  = ($urandom_range(0, 39) == 0);
      if (m_pend) begin
        if (!prev_pend) lat = $urandom_range(0, 4);
        if (lat > 0) begin
          lat--;
          mem_done = 1'b0;
        end else begin
          mem_done  = 1'b1;
          mem_block = blk(m_addr);
        end
      end else begin
        mem_done = 1'b0;
      end
      prev_pend = m_pend;
      if (m_served != seen || !fetch_valid) begin
        seen        = m_served;
        fetch_valid = ($urandom_range(0, 4) != 0);
        a = ($urandom_range(0, 3) << 8) | ($urandom_range(0, 3) << 4) | ($urandom_range(0, 3) << 2);
        if ($urandom_range(0, 7) == 0) a = a | 32'h0010_0000;
        fetch_addr = a;
      end
    end
    tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache between the instruction fetch unit and the memory controller. It serves 32-bit instruction reads from 1/2/4-way sets, chooses refill victims by tree pseudo-LRU, and runs its own miss FSM with a request/done handshake to memory. It supports a whole-cache flush (fence.i) and generalises the direct-mapped, externally-filled cache.

## Interface
- WAYS, 2: associativity; legal values 1, 2, 4.
- SETS, 16: number of sets; power of two, at least 2.
- BLOCK_BYTES, 16: line size in bytes; power of two, at least 4.
- ADDR_BITS, 17: significant address bits; tag is `ADDR_BITS - log2(SETS) - log2(BLOCK_BYTES)` bits.
- clk_in  input  1  clock.
- rst_in  input  1  reset, synchronous, active-high.
- rdy_in  input  1  global ready; low freezes all state.
- fetch_valid  input  1  fetch request; held stable with fetch_addr until inst_valid.
- fetch_addr  input  32  byte address, 4-byte aligned.
- inst_valid  output  1  inst_out valid this cycle.
- inst_out  output  32  little-endian word at fetch_addr.
- busy  output  1  miss FSM not IDLE.
- flush  input  1  invalidate all lines.
- mem_req  output  1  refill request, level, registered.
- mem_addr  output  32  block-aligned refill address, registered.
- mem_done  input  1  single-cycle pulse; mem_block valid.
- mem_block  input  BLOCK_BYTES*8  refill line; byte 0 in bits [7:0].

## Operation
- Address split:
  - offset = addr[log2(BLOCK_BYTES)-1:0].
  - index = next log2(SETS) bits.
  - tag = the bits above index, up to ADDR_BITS-1.
  - Bits at and above ADDR_BITS are ignored.
- Lookup is combinational. A hit is any way with valid set and matching tag.
- `inst_valid = fetch_valid && hit && rdy_in && state==IDLE && !flush`.
- `inst_out = line[offset*8 +: 32]` of the hitting way. It is 0 when there is no hit.
- FSM IDLE:
  - On fetch_valid && !hit && !flush, capture the block-aligned address into mem_addr.
  - Assert mem_req on the same edge and go to REFILL.
- FSM REFILL:
  - Hold mem_req and mem_addr stable until mem_done.
  - On mem_done: drop mem_req, install the line unless it is poisoned, go to IDLE.
- Victim selection: the lowest-index invalid way; otherwise the PLRU victim of the set.
- Install: set valid, write tag and data, update PLRU as an access to the victim way.
- Hit: update PLRU toward the hit way, on the edge where inst_valid is high.
- PLRU tree: WAYS-1 bits per set; WAYS=1 has no PLRU state.
- Flush:
  - Clears all valid bits and all PLRU bits on the edge it is sampled.
  - Flush during REFILL poisons the pending line: the handshake completes but the line is not installed.
  - Flush in the same cycle as mem_done also drops the line.
- rdy_in low: no state update, mem_req held, inst_valid 0. A mem_done arriving while rdy_in is low is not observed; the memory controller shares rdy_in.
- Reset: all valid and PLRU bits 0, state IDLE, mem_req 0, mem_addr 0, poison 0.
  - inst_valid is 0 because fetch_valid is gated by busy/hit.
  - Reset mid-REFILL abandons the request; the memory controller resets on the same rst_in.

## Timing
- Hit latency: 0 cycles (inst_valid in the request cycle).
- Miss:
  - mem_req is high at the first edge after the miss.
  - mem_done is sampled at edge N; the line becomes valid at N.
  - inst_valid is high in the cycle after N (hit path).
- Miss penalty: memory latency + 1 cycle.
- One outstanding refill only. Fetches during REFILL are not served; busy=1.

## Structure
- Shared constants go in const.v as macros: ICACHE_WAYS, ICACHE_SETS, ICACHE_BLOCK_BYTES, ICACHE_ADDR_BITS, and the derived bit widths. Module parameters default to these macros.
- FSM state encodings (IDLE, REFILL) are local parameters.
- Sub-module icache_plru, parametrised by WAYS, maps a set's PLRU bits:
  - to victim way (read path);
  - plus accessed way to new bits (update path);
  - combinational, one instance.
- Storage: per-way valid, tag and data arrays.

## Test plan
Defaults apply: index = addr[7:4], set 0 aliases 0x00000 / 0x00100 / 0x00200.
1. Cold miss at 0x00000 → mem_req=1 and mem_addr=0x00000 next edge. mem_done with word0=0x00000013 → inst_valid=1, inst_out=0x00000013 the cycle after.
2. After test 1, fetch 0x0000C, block word3=0xFE010113 → same-cycle hit, inst_out=0xFE010113, no mem_req.
3. Fill 0x00000 and 0x00100, re-hit 0x00000, miss 0x00200 → line 0x00100 evicted. 0x00000 hits; 0x00100 misses with mem_addr=0x00100.
4. Flush pulse in REFILL for 0x00300 → after mem_done, 0x00300 misses again. Previously filled 0x00000 misses.
5. rdy_in=0 on a hitting fetch → inst_valid=0, PLRU unchanged. rdy_in=0 held in REFILL → mem_req and mem_addr stable.
6. rst_in mid-REFILL → next cycle mem_req=0, busy=0; 0x00000 misses.
